int_controller: RTL
===================

# int_controller

Interrupt arbitration stage sitting directly downstream of the interrupt-enable register block. Captures 64 interrupt source lines into a pending register and masks them with the 64-bit `int_en` vector. Selects the highest-priority enabled pending source and presents it to the CPU core through a request/acknowledge/end-of-interrupt handshake. Only one interrupt is in service at a time; there is no nesting.

## Interface

Parameters:
- `N_SRC`, 64: number of interrupt sources. Fixed at 64 to match `int_en`.
- `ID_W`, 6: width of the interrupt ID, log2(`N_SRC`).

Ports:
- `clk`  input  1  system clock; one clock domain.
- `rst_n`  input  1  reset, synchronous and active-low.
- `irq_src`  input  64  raw interrupt source lines, already synchronous to `clk`.
- `int_en`  input  64  per-source enable mask from the enable register block; 1 = enabled.
- `int_req`  output  1  interrupt request to the CPU.
- `int_id`  output  6  ID of the requested or in-service source.
- `int_ack`  input  1  CPU accepts the current request; single-cycle pulse.
- `int_eoi`  input  1  CPU signals end of interrupt service; single-cycle pulse.
- `int_pending`  output  64  raw pending vector (unmasked), for status readback.
- `int_busy`  output  1  high while an interrupt is in service.

## Operation

- Pending capture (edge mode):
  - `src_q` registers `irq_src`.
  - `rise = irq_src & ~src_q`.
  - `pending <= (pending & ~clr) | rise`, where `clr` is a one-hot vector on `int_id`, active only in the cycle the ack is accepted.
- Simultaneous set and clear on the same bit: the set wins, so the bit stays pending.
- Candidate vector is `pending & int_en`. Priority is fixed: the lowest index wins, so bit 0 is the highest priority.
- Masked pending bits stay latched. They become eligible as soon as their `int_en` bit rises.
- FSM states: IDLE, REQ, SERV.
  - IDLE: if any candidate exists, go to REQ next cycle, latch `int_id` to the winner, and set `int_req=1`.
  - REQ: `int_id` is frozen, even if a higher-priority source arrives or the `int_en` bit drops.
    - If `int_ack=1`: clear pending[`int_id`], set `int_req=0`, set `int_busy=1`, go to SERV.
  - SERV: if `int_eoi=1`, set `int_busy=0` and go to IDLE. New edges keep latching during SERV.
- `int_ack` outside REQ and `int_eoi` outside SERV are ignored.
- Reset values: `pending`=0, `src_q`=0, state IDLE, `int_req`=0, `int_id`=0, `int_busy`=0. `int_pending`=0.
- Reset asserted mid-handshake aborts the handshake. All state returns to the reset values at the next `clk` edge, and any pending bits are lost.

## Timing

- An `irq_src` rise sampled at edge N sets pending visible after edge N.
- IDLE evaluates the candidate after edge N. `int_req` and `int_id` are registered high after edge N+1.
- Source-to-request latency is therefore 2 cycles.
- Ack sampled at edge M: `int_req` is low and the pending bit is clear after M.
- EOI sampled at edge K: the FSM is in IDLE after K, and the next `int_req` can come after K+1.
- Minimum back-to-back spacing is therefore 1 idle cycle between EOI and the next request.
- `int_req` stays high indefinitely until acked. There is no timeout.
- All outputs are registered. `int_pending` is the direct register output.

## Configuration

- Macro `INT_CTRL_EDGE_DETECT_EN`.
- Defined: edge-triggered capture as described above.
- Undefined: level-sensitive operation.
  - `pending` = `irq_src` combinationally registered each cycle, and `src_q` is removed.
  - Ack does not clear the bit.
  - The source must drop before `int_eoi`. Otherwise it re-requests one cycle after returning to IDLE.
  - Latency becomes 2 cycles from the level being sampled.

## Test plan

- Single source, edge mode: pulse `irq_src[5]` one cycle with `int_en`=all ones.
  - Expect `int_req`=1 and `int_id`=5 two cycles later.
  - Ack: `int_pending[5]`=0 and `int_busy`=1.
  - EOI: `int_busy`=0, `int_req` stays 0.
- Priority: raise bits 40 and 3 in the same cycle. Expect `int_id`=3 first. After EOI, expect a second request with `int_id`=40.
- Masking with `int_en`=64'hFFFFFFFE_FFFFFFFF (bit 32 off):
  - Pulse bit 32: `int_req` stays 0 and `int_pending[32]`=1.
  - Set `int_en[32]`=1: `int_req` asserts with `int_id`=32 one cycle later.
- Freeze and simultaneity: in REQ with `int_id`=10, raise bit 2. `int_id` stays 10.
  - In the ack cycle, re-edge bit 10: `int_pending[10]` stays 1.
- Spurious handshake: pulse `int_ack` in IDLE and `int_eoi` in REQ. The state is unchanged, with no pending clear.
- Reset mid-operation: in SERV with 3 pending bits, drive `rst_n`=0 for one edge. All outputs are 0 and the state is IDLE.
  - Repeat with the macro undefined: a held `irq_src[7]` re-requests after EOI.

Source files
------------

// File: rtl/int_controller.sv
// rtl/int_controller.sv - 64-source fixed-priority interrupt arbiter with req/ack/eoi handshake.
// INT_CTRL_EDGE_DETECT_EN selects edge capture; level-sensitive capture when undefined.
module int_controller #(
  parameter int N_SRC = 64,
  parameter int ID_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] int_en,
  output logic             int_req,
  output logic [ID_W-1:0]  int_id,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic [N_SRC-1:0] int_pending,
  output logic             int_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SERV = 2'd2;

  logic [1:0]       state;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] cand;
  logic [ID_W-1:0]  win_id;
  logic             any_cand;

`ifdef INT_CTRL_EDGE_DETECT_EN
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;

  always_comb begin
    rise = irq_src & ~src_q;
    clr  = '0;
    if (state == REQ && int_ack)
      clr = {{(N_SRC-1){1'b0}}, 1'b1} << int_id;
  end

  // OR-ing rise after the clear lets a fresh edge win over the ack clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr) | rise;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n)
      pending <= '0;
    else
      pending <= irq_src;
  end
`endif

  assign cand     = pending & int_en;
  assign any_cand = |cand;

  // Descending scan so the lowest set index is written last and wins
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i])
        win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      int_req  <= 1'b0;
      int_id   <= '0;
      int_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            state   <= REQ;
            int_id  <= win_id;
            int_req <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state    <= SERV;
            int_req  <= 1'b0;
            int_busy <= 1'b1;
          end
        end
        SERV: begin
          if (int_eoi) begin
            state    <= IDLE;
            int_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          int_req  <= 1'b0;
          int_busy <= 1'b0;
        end
      endcase
    end
  end

  assign int_pending = pending;

endmodule
